// File: rtl/fft_sink_pkg.sv
// Shared types and constants for the FFT output-channel sink and its source-side counterpart.
// Holds the sink state encoding, default geometry and the tdata {re, im} field split.
package fft_sink_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } sink_state_e;

  localparam int unsigned NFFT_DEF = 128;
  localparam int unsigned DW_DEF   = 24;
  localparam int unsigned IDXW_DEF = 7;

  // tdata = {re, im} at the default width
  localparam int unsigned RE_MSB = 2 * DW_DEF - 1;
  localparam int unsigned RE_LSB = DW_DEF;
  localparam int unsigned IM_MSB = DW_DEF - 1;
  localparam int unsigned IM_LSB = 0;

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage pipelined |x|^2 = re^2 + im^2 with an index/eligible sideband.
// No backpressure: a stage with in_valid low travels down the pipe as a bubble.
module cplx_mag_sq #(
  parameter int unsigned DW   = 24,
  parameter int unsigned IDXW = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  input  logic [IDXW-1:0] in_index,
  input  logic            in_eligible,
  output logic            out_valid,
  output logic [IDXW-1:0] out_index,
  output logic            out_eligible,
  output logic [2*DW-1:0] out_mag
);

  logic signed [2*DW-1:0] re_ext, im_ext;
  logic        [2*DW-1:0] s1_re2_q, s1_im2_q;
  logic        [IDXW-1:0] s1_idx_q;
  logic                   s1_valid_q, s1_elig_q;

  // Operands widened first so the squares are formed at full product width.
  assign re_ext = {{DW{in_re[DW-1]}}, in_re};
  assign im_ext = {{DW{in_im[DW-1]}}, in_im};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_elig_q  <= 1'b0;
      s1_idx_q   <= '0;
      s1_re2_q   <= '0;
      s1_im2_q   <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_elig_q <= in_eligible;
        s1_idx_q  <= in_index;
        s1_re2_q  <= re_ext * re_ext;
        s1_im2_q  <= im_ext * im_ext;
      end
    end
  end

  // Each square is at most 2^(2*DW-2), so the sum fits in 2*DW unsigned bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_eligible <= 1'b0;
      out_index    <= '0;
      out_mag      <= '0;
    end else begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        out_eligible <= s1_elig_q;
        out_index    <= s1_idx_q;
        out_mag      <= s1_re2_q + s1_im2_q;
      end
    end
  end

endmodule

// File: rtl/fft_peak_detector.sv
// AXI-Stream sink for one NFFT-bin complex spectrum per frame: finds the strongest eligible
// bin, checks frame length against tlast and hands {peak_bin, peak_mag} out on valid/ready.
module fft_peak_detector
  import fft_sink_pkg::*;
#(
  parameter int unsigned NFFT      = NFFT_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned IDXW      = IDXW_DEF,
  parameter bit          SKIP_DC   = 1'b1,
  parameter bit          HALF_SPEC = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*DW-1:0] s_axis_data_tdata,
  input  logic            s_axis_data_tvalid,
  output logic            s_axis_data_tready,
  input  logic            s_axis_data_tlast,
  output logic [IDXW-1:0] peak_bin,
  output logic [2*DW-1:0] peak_mag,
  output logic            peak_valid,
  input  logic            peak_ready,
  output logic            err_tlast_unexpected,
  output logic            err_tlast_missing,
  output logic [15:0]     frame_cnt
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFFT - 1);
  localparam logic [IDXW-1:0] HALF_IDX = IDXW'(NFFT / 2);

  sink_state_e     state_q, state_d;
  logic [IDXW-1:0] bin_cnt_q, bin_cnt_d;
  logic [1:0]      drain_cnt_q, drain_cnt_d;
  logic            tready_q;
  logic            accept, close, capture, release_res, eligible;

  logic            mag_valid, mag_elig;
  logic [IDXW-1:0] mag_idx;
  logic [2*DW-1:0] mag_sum;

  logic [2*DW-1:0] max_mag_q;
  logic [IDXW-1:0] max_bin_q;

  assign accept      = s_axis_data_tvalid && tready_q;
  assign close       = accept && (s_axis_data_tlast || (bin_cnt_q == LAST_IDX));
  assign capture     = (state_q == DRAIN) && (drain_cnt_q == 2'd2);
  assign release_res = (state_q == HOLD) && peak_valid && peak_ready;
  assign eligible    = !(SKIP_DC && (bin_cnt_q == '0)) &&
                       !(HALF_SPEC && (bin_cnt_q >= HALF_IDX));

  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE: state_d = ACCUM;
      ACCUM: begin
        if (accept) begin
          bin_cnt_d = close ? '0 : bin_cnt_q + 1'b1;
        end
        if (close) begin
          state_d     = DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      // Closing beat needs two edges to clear the pipe and one more for the compare stage.
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (capture) state_d = HOLD;
      end
      HOLD: begin
        if (release_res) state_d = ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_cnt_q   <= '0;
      drain_cnt_q <= 2'd0;
      tready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tready_q    <= (state_d == ACCUM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_tlast_unexpected <= 1'b0;
      err_tlast_missing    <= 1'b0;
    end else begin
      err_tlast_unexpected <= close && s_axis_data_tlast && (bin_cnt_q != LAST_IDX);
      err_tlast_missing    <= close && !s_axis_data_tlast && (bin_cnt_q == LAST_IDX);
    end
  end

  cplx_mag_sq #(
    .DW   (DW),
    .IDXW (IDXW)
  ) u_mag (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (accept),
    .in_re        (s_axis_data_tdata[2*DW-1:DW]),
    .in_im        (s_axis_data_tdata[DW-1:0]),
    .in_index     (bin_cnt_q),
    .in_eligible  (eligible),
    .out_valid    (mag_valid),
    .out_index    (mag_idx),
    .out_eligible (mag_elig),
    .out_mag      (mag_sum)
  );

  // Strict compare keeps the lowest index on ties; cleared as the result is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_mag_q <= '0;
      max_bin_q <= '0;
    end else if (capture) begin
      max_mag_q <= '0;
      max_bin_q <= '0;
    end else if (mag_valid && mag_elig && (mag_sum > max_mag_q)) begin
      max_mag_q <= mag_sum;
      max_bin_q <= mag_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      frame_cnt  <= 16'd0;
    end else if (capture) begin
      peak_valid <= 1'b1;
      peak_bin   <= max_bin_q;
      peak_mag   <= max_mag_q;
      frame_cnt  <= frame_cnt + 16'd1;
    end else if (release_res) begin
      peak_valid <= 1'b0;
    end
  end

  assign s_axis_data_tready = tready_q;

endmodule
